// File: rtl/fp32_pkg.sv
// Shared definitions for the sequential fp32 arithmetic units.
package fp32_pkg;

  // Controller state encoding
  typedef enum logic [3:0] {
    StGetA,
    StGetB,
    StUnpack,
    StSpecial,
    StNormA,
    StNormB,
    StMul0,
    StMul1,
    StMul2,
    StNorm1,
    StNorm2,
    StRound,
    StPack,
    StSetZ
  } fp_state_e;

  // Unbiased exponent markers: E_ZERO tags zero/subnormal, E_INF tags inf/NaN
  localparam logic signed [9:0] E_ZERO = 10'sh381;
  localparam logic signed [9:0] E_INF  = 10'sd128;
  localparam logic signed [9:0] E_SUBN = -10'sd126;
  localparam logic signed [9:0] E_MAX  = 10'sd127;
  localparam logic [7:0]        BIAS   = 8'd127;

  localparam logic [31:0] QNAN    = 32'hFFC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Biased 8-bit exponent field to signed internal exponent
  function automatic logic signed [9:0] unbias(input logic [7:0] e);
    return $signed({2'b00, e}) - $signed({2'b00, BIAS});
  endfunction

endpackage

// File: rtl/fp32_multiplier_if.sv
// Operand/result strobe-ack handshake of the fp32 multiplier.
interface fp32_multiplier_if;
  logic [31:0] ia;
  logic [31:0] ib;
  logic        i_stb_a;
  logic        i_stb_b;
  logic        i_ack;
  logic [31:0] o_z;
  logic        o_z_stb;
  logic        o_z_ack;

  modport master (
    output ia, ib, i_stb_a, i_stb_b, o_z_ack,
    input  i_ack, o_z, o_z_stb
  );

  modport slave (
    input  ia, ib, i_stb_a, i_stb_b, o_z_ack,
    output i_ack, o_z, o_z_stb
  );
endinterface

// File: rtl/fp_mul24_seq.sv
// Iterative shift-add significand multiplier, one multiplier bit per cycle.
module fp_mul24_seq #(
  parameter int unsigned MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MANT_W-1:0]     a_m,
  input  logic [MANT_W-1:0]     b_m,
  output logic [2*MANT_W-1:0]   prod,
  output logic                  done
);

  localparam int unsigned CntW = $clog2(MANT_W);

  logic [CntW-1:0]     cnt_q;
  logic                busy_q;
  logic [2*MANT_W-1:0] prod_q;

  // done is high during the final iteration so the caller leaves on the same edge
  assign done = busy_q && (cnt_q == CntW'(MANT_W - 1));
  assign prod = prod_q;

  // Accumulate a_m << cnt for every set bit of b_m
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      prod_q <= '0;
    end else if (start) begin
      cnt_q  <= '0;
      busy_q <= 1'b1;
      prod_q <= '0;
    end else if (busy_q) begin
      if (b_m[cnt_q]) begin
        prod_q <= prod_q + ({{MANT_W{1'b0}}, a_m} << cnt_q);
      end
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp32_multiplier.sv
// Sequential IEEE-754 single-precision multiplier, round-to-nearest-even.
module fp32_multiplier
  import fp32_pkg::*;
#(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 10
) (
  input logic               clk,
  input logic               rst,
  fp32_multiplier_if.slave  bus
);

  localparam logic signed [EXP_W-1:0] EOne = 1;

  fp_state_e               state_q;
  logic [31:0]             a_q, b_q, z_q, o_z_q;
  logic [MANT_W-1:0]       a_m_q, b_m_q, z_m_q;
  logic signed [EXP_W-1:0] a_e_q, b_e_q, z_e_q;
  logic                    a_s_q, b_s_q, z_s_q;
  logic                    guard_q, round_bit_q, sticky_q;
  logic                    i_ack_q, o_z_stb_q;

  logic                    mul_start, mul_done;
  logic [2*MANT_W-1:0]     prod;
  logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_nan  = (a_e_q == E_INF) && (a_m_q != '0);
  assign b_nan  = (b_e_q == E_INF) && (b_m_q != '0);
  assign a_inf  = (a_e_q == E_INF) && (a_m_q == '0);
  assign b_inf  = (b_e_q == E_INF) && (b_m_q == '0);
  assign a_zero = (a_e_q == E_ZERO) && (a_m_q == '0);
  assign b_zero = (b_e_q == E_ZERO) && (b_m_q == '0);

  assign mul_start   = (state_q == StMul0);
  assign bus.i_ack   = i_ack_q;
  assign bus.o_z     = o_z_q;
  assign bus.o_z_stb = o_z_stb_q;

  fp_mul24_seq #(
    .MANT_W (MANT_W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a_m   (a_m_q),
    .b_m   (b_m_q),
    .prod  (prod),
    .done  (mul_done)
  );

  // Controller: operand capture, classification, multiply, normalise, round, pack, hand off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StGetA;
      a_q         <= '0;
      b_q         <= '0;
      z_q         <= '0;
      o_z_q       <= '0;
      a_m_q       <= '0;
      b_m_q       <= '0;
      z_m_q       <= '0;
      a_e_q       <= '0;
      b_e_q       <= '0;
      z_e_q       <= '0;
      a_s_q       <= 1'b0;
      b_s_q       <= 1'b0;
      z_s_q       <= 1'b0;
      guard_q     <= 1'b0;
      round_bit_q <= 1'b0;
      sticky_q    <= 1'b0;
      i_ack_q     <= 1'b0;
      o_z_stb_q   <= 1'b0;
    end else begin
      case (state_q)
        StGetA: begin
          i_ack_q <= 1'b1;
          if (i_ack_q && bus.i_stb_a) begin
            a_q     <= bus.ia;
            i_ack_q <= 1'b0;
            state_q <= StGetB;
          end
        end
        StGetB: begin
          i_ack_q <= 1'b1;
          if (i_ack_q && bus.i_stb_b) begin
            b_q     <= bus.ib;
            i_ack_q <= 1'b0;
            state_q <= StUnpack;
          end
        end
        StUnpack: begin
          a_m_q   <= {1'b0, a_q[22:0]};
          b_m_q   <= {1'b0, b_q[22:0]};
          a_e_q   <= unbias(a_q[30:23]);
          b_e_q   <= unbias(b_q[30:23]);
          a_s_q   <= a_q[31];
          b_s_q   <= b_q[31];
          state_q <= StSpecial;
        end
        StSpecial: begin
          state_q <= StSetZ;
          if (a_nan || b_nan) begin
            z_q <= QNAN;
          end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            z_q <= QNAN;
          end else if (a_inf || b_inf) begin
            z_q <= POS_INF | {a_s_q ^ b_s_q, 31'd0};
          end else if (a_zero || b_zero) begin
            z_q <= {a_s_q ^ b_s_q, 31'd0};
          end else begin
            // Subnormals keep a zero hidden bit and take the minimum exponent
            if (a_e_q == E_ZERO) a_e_q <= E_SUBN;
            else                 a_m_q[MANT_W-1] <= 1'b1;
            if (b_e_q == E_ZERO) b_e_q <= E_SUBN;
            else                 b_m_q[MANT_W-1] <= 1'b1;
            state_q <= StNormA;
          end
        end
        StNormA: begin
          if (!a_m_q[MANT_W-1]) begin
            a_m_q <= a_m_q << 1;
            a_e_q <= a_e_q - EOne;
          end else begin
            state_q <= StNormB;
          end
        end
        StNormB: begin
          if (!b_m_q[MANT_W-1]) begin
            b_m_q <= b_m_q << 1;
            b_e_q <= b_e_q - EOne;
          end else begin
            state_q <= StMul0;
          end
        end
        StMul0: begin
          // +1 because the product's top bit weighs 2^1
          z_s_q   <= a_s_q ^ b_s_q;
          z_e_q   <= a_e_q + b_e_q + EOne;
          state_q <= StMul1;
        end
        StMul1: begin
          if (mul_done) state_q <= StMul2;
        end
        StMul2: begin
          z_m_q       <= prod[2*MANT_W-1:MANT_W];
          guard_q     <= prod[MANT_W-1];
          round_bit_q <= prod[MANT_W-2];
          sticky_q    <= |prod[MANT_W-3:0];
          state_q     <= StNorm1;
        end
        StNorm1: begin
          if (!z_m_q[MANT_W-1] && (z_e_q > E_SUBN)) begin
            z_m_q       <= {z_m_q[MANT_W-2:0], guard_q};
            z_e_q       <= z_e_q - EOne;
            guard_q     <= round_bit_q;
            round_bit_q <= 1'b0;
          end else begin
            state_q <= StNorm2;
          end
        end
        StNorm2: begin
          // Denormalise results below the minimum exponent
          if (z_e_q < E_SUBN) begin
            z_e_q       <= z_e_q + EOne;
            z_m_q       <= z_m_q >> 1;
            guard_q     <= z_m_q[0];
            round_bit_q <= guard_q;
            sticky_q    <= sticky_q | round_bit_q;
          end else begin
            state_q <= StRound;
          end
        end
        StRound: begin
          if (guard_q && (round_bit_q || sticky_q || z_m_q[0])) begin
            z_m_q <= z_m_q + 1'b1;
            if (&z_m_q) z_e_q <= z_e_q + EOne;
          end
          state_q <= StPack;
        end
        StPack: begin
          z_q <= {z_s_q, z_e_q[7:0] + BIAS, z_m_q[22:0]};
          if ((z_e_q == E_SUBN) && !z_m_q[MANT_W-1]) z_q[30:23] <= 8'd0;
          if (z_e_q > E_MAX) z_q <= POS_INF | {z_s_q, 31'd0};
          state_q <= StSetZ;
        end
        StSetZ: begin
          o_z_q     <= z_q;
          o_z_stb_q <= 1'b1;
          if (o_z_stb_q && bus.o_z_ack) begin
            o_z_stb_q <= 1'b0;
            state_q   <= StGetA;
          end
        end
        default: state_q <= StGetA;
      endcase
    end
  end

endmodule

// File: doc/fp32_multiplier.md
Name: fp32_multiplier

Overview:
- Sequential IEEE-754 single-precision multiplier. Companion to the ALU's fp32 divider: it uses the same operand/result strobe-ack handshake and the same special-value encodings.
- Accepts operand a, then operand b, and returns z = a*b, rounded to nearest-even, with subnormal support.
- The mantissa product is formed by an iterative shift-add, one bit per cycle, to keep area at ALU scale.

Parameters:
- MANT_W, 24, significand width including the hidden bit.
- EXP_W, 10, internal signed exponent width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ia  in  32  operand a, sampled when i_ack && i_stb_a in the get_a state.
- ib  in  32  operand b, sampled when i_ack && i_stb_b in the get_b state.
- i_stb_a  in  1  operand a valid.
- i_stb_b  in  1  operand b valid.
- i_ack  out  1  operand ready; registered.
- o_z  out  32  result; registered; stable while o_z_stb=1.
- o_z_stb  out  1  result valid.
- o_z_ack  in  1  consumer accepts the result.

Behaviour:
- Reset (rst=0, asynchronous): state=get_a, i_ack=0, o_z_stb=0, o_z=0.
- States: get_a, get_b, unpack, special, normalize_a, normalize_b, mul_0, mul_1, mul_2, normalize_1, normalize_2, round, pack, set_z.
- get_a:
  - i_ack<=1.
  - On i_ack && i_stb_a: latch a, i_ack<=0, go to get_b.
  - i_ack is therefore low for at least one cycle between the a and b transfers.
- get_b: same rule with ib/i_stb_b; go to unpack.
- unpack:
  - m = bits[22:0], e = bits[30:23]-127 (10-bit signed), s = bit 31.
  - e=-127 denotes zero/subnormal; e=128 denotes inf/NaN.
- special, checked in priority order:
  - Any NaN operand -> z=0xFFC00000.
  - inf*0 or 0*inf -> 0xFFC00000.
  - inf*x or x*inf -> sign a_s^b_s, exponent 255, mantissa 0.
  - 0*x or x*0 -> signed zero, sign a_s^b_s.
  - Otherwise: subnormal operand gets e=-126; normal operand gets hidden bit m[23]=1. Go to normalize_a.
  - All special results go directly to set_z.
- normalize_a / normalize_b: while m[23]=0, shift m left by 1 and decrement e, one bit per cycle.
- mul_0: z_s=a_s^b_s, z_e=a_e+b_e+1, 48-bit product=0, cnt=0.
- mul_1, one cycle per iteration:
  - If b_m[cnt], product += a_m<<cnt.
  - After cnt=23, go to mul_2. Exactly 24 cycles.
- mul_2: z_m=prod[47:24], guard=prod[23], round_bit=prod[22], sticky=|prod[21:0].
- normalize_1: while z_m[23]=0 and z_e>-126, shift left one bit per cycle, shifting guard into z_m[0], round_bit into guard, 0 into round_bit.
- normalize_2: while z_e<-126:
  - z_e+=1, z_m>>=1.
  - guard<=z_m[0], round_bit<=guard, sticky|=round_bit.
- round:
  - If guard && (round_bit|sticky|z_m[0]), then z_m+=1.
  - If z_m was 0xFFFFFF, z_e+=1.
- pack:
  - z={z_s, z_e[7:0]+127, z_m[22:0]}.
  - z_e=-126 && z_m[23]=0 -> exponent field 0 (subnormal).
  - z_e>127 -> signed infinity.
- set_z:
  - o_z<=z, o_z_stb<=1.
  - On o_z_stb && o_z_ack: o_z_stb<=0, go to get_a.
  - o_z is held unchanged while waiting for o_z_ack.
- Latency, measured from the edge accepting b to the edge setting o_z_stb, for normal operands with a normal result:
  - 35 cycles if the product is ≥2.
  - 36 cycles if the product is <2.
- Special-case latency: 3 cycles.
- Reset asserted mid-operation aborts immediately. No partial result is emitted; the next transaction is unaffected.
- i_stb_* asserted outside get_a/get_b is ignored. i_ack=0 throughout computation.

Decomposition:
- Shared package fp32_pkg holds:
  - State encoding (4-bit).
  - E_ZERO=10'h381 (-127), E_INF=128, BIAS=127.
  - QNAN=32'hFFC00000, POS_INF=32'h7F800000.
  - The same package is used by the fp32 divider.
- One natural sub-module: fp_mul24_seq, the iterative 24x24 shift-add unit.
  - Interface: start, a_m, b_m in; prod[47:0], done out.
  - The top FSM waits in mul_1 until done.

Test Plan:
- 0x3FC00000 * 0x3FC00000 (1.5*1.5) -> o_z=0x40100000, o_z_stb 35 cycles after b accepted. 0x3F800000*0x3F800000 -> 0x3F800000 in 36 cycles.
- Rounding: 0x3F800001 * 0x3F800001 -> 0x3F800002. 0x00000001 * 0x3FC00000 -> 0x00000002. 0x00000001 * 0x3E800000 -> 0x00000000.
- Specials:
  - 0x7F800000 * 0x00000000 -> 0xFFC00000.
  - 0xFF800000 * 0x40000000 -> 0xFF800000.
  - 0x7FC00000 * 0x3F800000 -> 0xFFC00000.
  - 0x80000000 * 0x40400000 -> 0x80000000.
- Overflow/underflow: 0x7F7FFFFF * 0x40000000 -> 0x7F800000. 0x00800000 * 0x3F000000 -> 0x00400000 (subnormal).
- Handshake:
  - Hold o_z_ack=0 for 10 cycles -> o_z_stb stays 1 and o_z is constant.
  - i_ack=0 from b acceptance until the return to get_a.
  - Back-to-back transactions both produce correct results.
- Reset: drive rst=0 during mul_1 -> i_ack, o_z_stb, o_z are 0 immediately without a clock edge. After release, 0x40000000 * 0x40400000 -> 0x40C00000.
